// File: rtl/t_meas_pkg.sv
// Shared types and constants for the measurement-window controller.
package t_meas_pkg;

    localparam int CNT_W_DEF  = 12;
    localparam int WIN_W_DEF  = 16;
    localparam int SETTLE_LEN = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_COUNT,
        ST_SETTLE,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/t_meas_ctrl_rise_detect.sv
// Two-flop synchronizer plus previous-value flop; rise is high for one cycle
// two cycles after a 0->1 of sig_in is sampled, never stalls.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/t_meas_ctrl.sv
// Measurement-window controller: clear, count N cycles, settle, hold result; res_ovf built only with T_MEAS_OVF_EN.
// Result valid start+3+N cycles; held in HOLD until res_ready, abort cancels anywhere.
module t_meas_ctrl
    import t_meas_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIN_W-1:0] win_len,
    input  logic             sig_in,
    output logic             cnt_enb,
    output logic             cnt_rise,
    input  logic [CNT_W-1:0] cnt_val,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_cnt,
    output logic             res_ovf,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic [WIN_W-1:0] win_cnt;
    logic             rise;
    logic             last_cyc;

    rise_detect u_rise (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .rise   (rise)
    );

    // win_cnt doubles as the settle timer once the window is done
    assign last_cyc = (win_cnt == WIN_W'(1));

    always_comb begin
        state_nxt = state;
        cnt_enb   = 1'b0;
        cnt_rise  = 1'b0;
        res_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_nxt = ST_COUNT;
            end
            ST_COUNT: begin
                cnt_enb  = 1'b1;
                cnt_rise = rise;
                if (last_cyc) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                cnt_enb = 1'b1;
                if (last_cyc) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
            cnt_enb   = 1'b0;
            cnt_rise  = 1'b0;
            res_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            win_cnt <= '0;
            res_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (start && !abort)
                        win_cnt <= (win_len == '0) ? WIN_W'(1) : win_len;
                end
                ST_COUNT: begin
                    if (last_cyc) win_cnt <= WIN_W'(SETTLE_LEN);
                    else          win_cnt <= win_cnt - WIN_W'(1);
                end
                ST_SETTLE: begin
                    if (last_cyc) begin
                        if (!abort) res_cnt <= cnt_val;
                    end else begin
                        win_cnt <= win_cnt - WIN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef T_MEAS_OVF_EN
    logic res_ovf_q;

    // the increment that wraps the counter is the one issued while it reads all ones
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_ovf_q <= 1'b0;
        end else if (state == ST_CLEAR) begin
            res_ovf_q <= 1'b0;
        end else if (cnt_rise && (cnt_val == {CNT_W{1'b1}})) begin
            res_ovf_q <= 1'b1;
        end
    end

    assign res_ovf = res_ovf_q;
`else
    assign res_ovf = 1'b0;
`endif

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_t_meas_ctrl.sv
// Directed + randomized bench for t_meas_ctrl with a stand-in counter and a rise-count reference model.
module tb_t_meas_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] win_len;
    logic        sig_in;
    logic        cnt_enb;
    logic        cnt_rise;
    logic [11:0] cnt_val = '0;
    logic        res_valid;
    logic        res_ready;
    logic [11:0] res_cnt;
    logic        res_ovf;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pat_mode = 0;
    int pat_base = 0;
    bit hist [0:32767];
    logic [11:0] last_res;

    t_meas_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .win_len   (win_len),
        .sig_in    (sig_in),
        .cnt_enb   (cnt_enb),
        .cnt_rise  (cnt_rise),
        .cnt_val   (cnt_val),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_cnt   (res_cnt),
        .res_ovf   (res_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stand-in for the external 12-bit counter instance
    always_ff @(posedge clk) begin
        cnt_val <= cnt_enb ? cnt_val + {11'b0, cnt_rise} : 12'd0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one cycle and drive this cycle's sig_in from the active pattern
    task automatic next_cycle();
        bit v;
        @(posedge clk);
        #1;
        cyc++;
        case (pat_mode)
            1:       v = ((cyc - pat_base) % 4) inside {1, 2};
            2:       v = ((cyc - pat_base) % 2) == 1;
            3:       v = bit'($urandom_range(0, 1));
            default: v = 1'b0;
        endcase
        sig_in    = v;
        hist[cyc] = v;
        #1;
    endtask

    task automatic idle(input int k, input int mode);
        pat_mode = mode;
        repeat (k) next_cycle();
    endtask

    // rises of sig_in sampled in cycles [t, t+n-1] are exactly those landing in COUNT
    function automatic int rises(input int t, input int n);
        int c = 0;
        for (int i = t; i < t + n; i++)
            if (hist[i] && !hist[i-1]) c++;
        return c;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_enb"},   cnt_enb,   0);
        chk({tag, "_rise"},  cnt_rise,  0);
        chk({tag, "_valid"}, res_valid, 0);
        chk({tag, "_cnt"},   res_cnt,   0);
        chk({tag, "_ovf"},   res_ovf,   0);
        chk({tag, "_busy"},  busy,      0);
    endtask

    task automatic run_win(input int wl, input int mode, input int hold, input bit poke, input int fixed);
        int n, t, e_rise;
        logic [11:0] e_cnt;
        logic e_ovf;
        n = (wl == 0) ? 1 : wl;
        t = cyc;
        pat_base = cyc;
        pat_mode = mode;
        start = 1'b1;
        win_len = 16'(wl);
        next_cycle();
        start = 1'b0;
        win_len = 16'($urandom);
        chk("busy_clear", busy, 1);
        chk("enb_clear", cnt_enb, 0);
        next_cycle();
        chk("enb_count", cnt_enb, 1);
        while (cyc < t + 2 + n) begin
            chk("rise_count", cnt_rise, hist[cyc-2] && !hist[cyc-3]);
            next_cycle();
        end
        chk("settle_valid", res_valid, 0);
        chk("settle_rise", cnt_rise, 0);
        chk("settle_enb", cnt_enb, 1);
        next_cycle();
        e_rise = rises(t, n);
        e_cnt  = 12'(e_rise % 4096);
`ifdef T_MEAS_OVF_EN
        e_ovf = (e_rise >= 4096);
`else
        e_ovf = 1'b0;
`endif
        chk("valid_t3n", res_valid, 1);
        chk("res_cnt", res_cnt, e_cnt);
        chk("res_ovf", res_ovf, e_ovf);
        chk("hold_enb", cnt_enb, 0);
        if (fixed >= 0) chk("res_cnt_fixed", res_cnt, fixed);
        for (int i = 0; i < hold; i++) begin
            res_ready = 1'b0;
            start = poke && (i % 2 == 0);
            next_cycle();
            chk("hold_valid", res_valid, 1);
            chk("hold_cnt", res_cnt, e_cnt);
            chk("hold_ovf", res_ovf, e_ovf);
        end
        start = 1'b0;
        res_ready = 1'b1;
        next_cycle();
        res_ready = 1'b0;
        chk("post_valid", res_valid, 0);
        chk("post_busy", busy, 0);
        last_res = e_cnt;
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        win_len = '0;
        sig_in = 1'b0;
        res_ready = 1'b0;
        last_res = '0;
        idle(3, 0);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        idle(3, 0);

        // period-4 square wave, 3 pulses inside a 10-cycle window
        run_win(10, 1, 0, 0, 3);
        idle(3, 0);
        // zero length behaves as one cycle
        run_win(0, 0, 0, 0, 0);
        idle(3, 0);
        // 4500 pulses wrap the 12-bit counter
        run_win(9000, 2, 0, 0, 404);

        // abort in the fifth COUNT cycle
        idle(3, 3);
        t = cyc;
        start = 1'b1;
        win_len = 16'd20;
        next_cycle();
        start = 1'b0;
        while (cyc < t + 6) next_cycle();
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_enb", cnt_enb, 0);
        chk("abort_valid", res_valid, 0);
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            chk("abort_no_valid", res_valid, 0);
        end
        chk("abort_keep_cnt", res_cnt, last_res);
        idle(3, 0);
        run_win(4, 1, 0, 0, 1);

        // stalled consumer with start pokes in HOLD
        idle(3, 0);
        run_win($urandom_range(5, 40), 3, 7, 1, -1);

        // reset in the middle of COUNT
        idle(3, 3);
        t = cyc;
        start = 1'b1;
        win_len = 16'd30;
        next_cycle();
        start = 1'b0;
        while (cyc < t + 5) next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        chk_reset_outputs("midrst");
        idle(4, 0);
        run_win(12, 3, 1, 0, -1);

        for (int k = 0; k < 6; k++) begin
            idle($urandom_range(1, 3), 3);
            run_win($urandom_range(0, 60), 3, $urandom_range(0, 4), 1'b1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/t_meas_ctrl.md
# t_meas_ctrl

Measurement-window controller for the 12-bit rise-event counter in the pattern-timing datapath. On `start` it clears the counter, then enables it for exactly `win_len` clock cycles while feeding it synchronized rising-edge pulses from `sig_in`. It then waits one settle cycle, captures the final count and presents it on a valid/ready result port. It sits between the pattern sequencer, which issues `start` and consumes the result, and the counter instance.

## Interface
- `CNT_W`, 12: counter width; must match the counter instance.
- `WIN_W`, 16: window-length width.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle request to run a window; honored only in IDLE.
- `abort`  in  1  cancel any window; dominates `start`.
- `win_len`  in  WIN_W  window length in cycles; sampled on accepted `start`; 0 treated as 1.
- `sig_in`  in  1  asynchronous pattern input.
- `cnt_enb`  out  1  counter enable; low clears the counter.
- `cnt_rise`  out  1  counter increment pulse.
- `cnt_val`  in  CNT_W  counter value.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_cnt`  out  CNT_W  captured count.
- `res_ovf`  out  1  counter wrapped during the window.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, CLEAR, COUNT, SETTLE, HOLD.
- IDLE: `cnt_enb`=0. On `start` && !`abort`: latch `win_len` (0 becomes 1) into the window down-counter, then go to CLEAR.
- CLEAR: 1 cycle with `cnt_enb`=0, which guarantees the counter is zero. Clear `res_ovf`. Go to COUNT.
- COUNT: exactly N cycles with `cnt_enb`=1 and `cnt_rise` = edge-detector output. Decrement the window counter each cycle. After the Nth cycle go to SETTLE.
- SETTLE: 1 cycle with `cnt_enb`=1 and `cnt_rise`=0, so an increment from the last COUNT cycle lands. Register `cnt_val` into `res_cnt` at the end of this cycle. Go to HOLD.
- HOLD: `res_valid`=1 and `cnt_enb`=0. `res_cnt` and `res_ovf` stay stable. On `res_valid` && `res_ready` go to IDLE. `start` is ignored in HOLD.
- `abort` in any state: next state is IDLE, `cnt_enb`=0, `res_valid`=0, no result produced. `res_cnt` keeps its old value.
- Edge detector: 2-flop synchronizer plus a previous-value flop. A pulse is produced when the synchronized value is 1 and the previous value is 0. Pulses are at least 2 cycles apart.
- Only pulses falling inside COUNT cycles reach `cnt_rise`; all others are dropped.
- Arithmetic: the count wraps modulo 2^CNT_W, so 4096 edges give `res_cnt`=0.

## Timing
- Reset values (`rst_n` low at a clock edge): state IDLE, `cnt_enb`=0, `cnt_rise`=0, `res_valid`=0, `res_cnt`=0, `res_ovf`=0, `busy`=0, synchronizer flops 0.
- Reset mid-window behaves like `abort` and also zeroes all outputs.
- `start` at cycle t gives: `busy` high at t+1 (CLEAR), COUNT from t+2 to t+1+N, SETTLE at t+2+N, `res_valid` at t+3+N.
- A `sig_in` rise sampled at edge k produces a `cnt_rise` pulse in cycle k+2 if that cycle is a COUNT cycle.
- `res_valid` deasserts the cycle after the handshake. The earliest next `start` acceptance is the first IDLE cycle.

## Configuration
- `T_MEAS_OVF_EN` defined: `res_ovf` is set and sticky when `cnt_rise`=1 && `cnt_val`=2^CNT_W−1 in COUNT. It is cleared in CLEAR.
- `T_MEAS_OVF_EN` undefined: the port still exists, `res_ovf` is tied to 0 and no overflow logic is built.

## Structure
- Package `t_meas_pkg` holds:
  - the state enum;
  - `CNT_W_DEF`=12 and `WIN_W_DEF`=16;
  - the SETTLE length constant (1).
- Sub-module `rise_detect` holds the synchronizer and edge detector. It has ports `clk`, `rst_n`, `sig_in` and `rise`.

## Test plan
- `win_len`=10 with a `sig_in` square wave of period 4 aligned so that 3 pulses fall in COUNT: `res_cnt`=3, `res_valid` at t+13.
- `win_len`=0 with no edges: behaves as N=1, `res_cnt`=0, `res_valid` at t+4.
- `win_len`=9000 with `sig_in` toggling every cycle, giving 4500 pulses:
  - with `T_MEAS_OVF_EN`: `res_cnt`=404, `res_ovf`=1;
  - without it: `res_ovf`=0.
- `abort` during COUNT cycle 5: IDLE next cycle, `cnt_enb`=0, no `res_valid`. A following `start` with `win_len`=4 and 1 pulse gives `res_cnt`=1.
- Hold `res_ready`=0 for 7 cycles in HOLD and pulse `start` meanwhile: `res_valid` and `res_cnt` are stable and `start` is ignored. Handshake leads to IDLE the next cycle.
- Drive `rst_n`=0 for 1 cycle mid-COUNT: all outputs at reset values next cycle, then a normal window completes correctly.
